// File: rtl/mpu_tile_seq_if.sv
// Handshake and control bundle between the MPU tile sequencer and its neighbours
// (command queue, C/A/B operand buffers, result writeback, tile enables).
interface mpu_tile_seq_if #(
    parameter int KW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [KW-1:0] cmd_k;
    logic          cmd_ldc;
    logic          cmd_st;
    logic          c_in_valid;
    logic          c_in_ready;
    logic          ab_valid;
    logic          ab_ready;
    logic          c_out_valid;
    logic          c_out_ready;
    logic          en_c;
    logic          en_ab;
    logic          acc_clr;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cnt;

    modport master (
        output cmd_valid, cmd_k, cmd_ldc, cmd_st, c_in_valid, ab_valid, c_out_ready,
        input  cmd_ready, c_in_ready, ab_ready, c_out_valid, en_c, en_ab, acc_clr,
               busy, done, stall_cnt
    );

    modport slave (
        input  cmd_valid, cmd_k, cmd_ldc, cmd_st, c_in_valid, ab_valid, c_out_ready,
        output cmd_ready, c_in_ready, ab_ready, c_out_valid, en_c, en_ab, acc_clr,
               busy, done, stall_cnt
    );
endinterface

// File: rtl/mpu_tile_seq.sv
// Command-level sequencer for the MPU systolic tile: C preload, K operand beats, drain, C store.
// Optional stall performance counter is built when MPU_TILE_SEQ_PERF_EN is defined.
module mpu_tile_seq #(
    parameter int ML    = 2,
    parameter int KW    = 8,
    parameter int DRAIN = 3
) (
    input  logic          clk,
    input  logic          reset,
    mpu_tile_seq_if.slave bus
);
    localparam int RW = $clog2(ML + 1);
    localparam int DW = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDC   = 3'd1,
        S_OPACC = 3'd2,
        S_DRAIN = 3'd3,
        S_STC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_r;
    logic [KW-1:0] k_r;
    logic          ldc_r;
    logic          st_r;
    logic [RW-1:0] row_cnt_r;
    logic [KW-1:0] beat_cnt_r;
    logic [DW-1:0] drain_cnt_r;
    logic [31:0]   stall_cnt_s;

    logic cmd_ready_s, c_in_ready_s, ab_ready_s, c_out_valid_s;
    logic en_c_s, en_ab_s, acc_clr_s, done_s;

    // Phase sequencing, command capture and row/beat/drain counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            k_r         <= {KW{1'b0}};
            ldc_r       <= 1'b0;
            st_r        <= 1'b0;
            row_cnt_r   <= {RW{1'b0}};
            beat_cnt_r  <= {KW{1'b0}};
            drain_cnt_r <= {DW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        k_r   <= bus.cmd_k;
                        ldc_r <= bus.cmd_ldc;
                        st_r  <= bus.cmd_st;
                        if (bus.cmd_ldc)
                            state_r <= S_LDC;
                        else if (bus.cmd_k != {KW{1'b0}})
                            state_r <= S_OPACC;
                        else
                            state_r <= S_DRAIN;
                    end
                end
                S_LDC: begin
                    if (bus.c_in_valid) begin
                        if (row_cnt_r == RW'(ML - 1)) begin
                            row_cnt_r <= {RW{1'b0}};
                            state_r   <= (k_r != {KW{1'b0}}) ? S_OPACC : S_DRAIN;
                        end else begin
                            row_cnt_r <= row_cnt_r + RW'(1);
                        end
                    end
                end
                S_OPACC: begin
                    if (bus.ab_valid) begin
                        if (beat_cnt_r == k_r - KW'(1)) begin
                            beat_cnt_r <= {KW{1'b0}};
                            state_r    <= S_DRAIN;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == DW'(DRAIN - 1)) begin
                        drain_cnt_r <= {DW{1'b0}};
                        state_r     <= st_r ? S_STC : S_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                    end
                end
                S_STC: begin
                    if (bus.c_out_ready) begin
                        if (row_cnt_r == RW'(ML - 1)) begin
                            row_cnt_r <= {RW{1'b0}};
                            state_r   <= S_DONE;
                        end else begin
                            row_cnt_r <= row_cnt_r + RW'(1);
                        end
                    end
                end
                S_DONE: begin
                    row_cnt_r   <= {RW{1'b0}};
                    beat_cnt_r  <= {KW{1'b0}};
                    drain_cnt_r <= {DW{1'b0}};
                    state_r     <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Per-phase handshake and enable decode; en_c and en_ab live in disjoint phases.
    always_comb begin
        cmd_ready_s   = 1'b0;
        c_in_ready_s  = 1'b0;
        ab_ready_s    = 1'b0;
        c_out_valid_s = 1'b0;
        en_c_s        = 1'b0;
        en_ab_s       = 1'b0;
        acc_clr_s     = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                cmd_ready_s = 1'b1;
                acc_clr_s   = bus.cmd_valid & ~bus.cmd_ldc;
            end
            S_LDC: begin
                c_in_ready_s = 1'b1;
                en_c_s       = bus.c_in_valid;
            end
            S_OPACC: begin
                ab_ready_s = 1'b1;
                en_ab_s    = bus.ab_valid;
            end
            S_STC: begin
                c_out_valid_s = 1'b1;
                en_c_s        = bus.c_out_ready;
            end
            S_DONE:  done_s = 1'b1;
            default: done_s = 1'b0;
        endcase
    end

`ifdef MPU_TILE_SEQ_PERF_EN
    logic [31:0] stall_cnt_r;
    logic        stall_s;

    // A stall is a cycle in a handshake phase whose partner is not ready.
    always_comb begin
        stall_s = ((state_r == S_LDC)   & ~bus.c_in_valid) |
                  ((state_r == S_OPACC) & ~bus.ab_valid)   |
                  ((state_r == S_STC)   & ~bus.c_out_ready);
    end

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_r <= 32'd0;
        else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF))
            stall_cnt_r <= stall_cnt_r + 32'd1;
        else
            stall_cnt_r <= stall_cnt_r;
    end

    assign stall_cnt_s = stall_cnt_r;
`else
    assign stall_cnt_s = 32'd0;
`endif

    // Every output is forced low while reset is asserted.
    assign bus.cmd_ready   = cmd_ready_s   & ~reset;
    assign bus.c_in_ready  = c_in_ready_s  & ~reset;
    assign bus.ab_ready    = ab_ready_s    & ~reset;
    assign bus.c_out_valid = c_out_valid_s & ~reset;
    assign bus.en_c        = en_c_s        & ~reset;
    assign bus.en_ab       = en_ab_s       & ~reset;
    assign bus.acc_clr     = acc_clr_s     & ~reset;
    assign bus.done        = done_s        & ~reset;
    assign bus.busy        = (state_r != S_IDLE) & ~reset;
    assign bus.stall_cnt   = reset ? 32'd0 : stall_cnt_s;
endmodule

// File: doc/mpu_tile_seq.md
# mpu_tile_seq

Command-level sequencer for the MPU systolic tile. It accepts one matmul-tile command at a time and steps the tile's accumulator shift chain and operand path through fixed phases: optional C preload, K operand beats, pipeline drain, and optional result shift-out. It drives the tile's `en_c`/`en_ab` enables and replaces ad-hoc per-phase enable logic. It sits between the MPU command queue, the C/A/B operand buffers and the result writeback port.

## Interface
- `ML`, default 2: accumulator rows shifted per C load/store, ≥1.
- `KW`, default 8: width of the K beat count.
- `DRAIN`, default 3: fixed drain cycles after the last A/B beat, ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_k` in KW: number of A/B beats; 0 is legal.
- `cmd_ldc` in 1: preload C from `c_in`; if 0, clear the accumulators.
- `cmd_st` in 1: shift the result out after drain.
- `c_in_valid` in 1, `c_in_ready` out 1: C preload row handshake.
- `ab_valid` in 1, `ab_ready` out 1: A/B operand beat handshake.
- `c_out_valid` out 1, `c_out_ready` in 1: result row handshake.
- `en_c` out 1: advance the accumulator shift chain one row.
- `en_ab` out 1: advance the operand path one beat.
- `acc_clr` out 1: clear all accumulators.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at command completion.
- `stall_cnt` out 32: performance stall counter (see Configuration).

## Operation
- States: IDLE, LDC, OPACC, DRAIN, STC, DONE. State is registered and is IDLE at reset.
- Command register holds k, ldc and st. Row counter is $clog2(ML+1) bits; beat counter is KW bits; drain counter is $clog2(DRAIN+1) bits. All are zero at reset.
- IDLE:
  - `cmd_ready`=1. Accept on `cmd_valid`.
  - Next state is LDC if ldc=1. Otherwise `acc_clr`=1 in the accept cycle, and next state is OPACC if k>0, else DRAIN.
- LDC:
  - `c_in_ready`=1 and `en_c`=`c_in_valid`.
  - Count accepted rows. On the ML-th row, go to OPACC if k>0, else DRAIN.
- OPACC:
  - `ab_ready`=1 and `en_ab`=`ab_valid`.
  - Count beats. On beat k, go to DRAIN. A cycle without `ab_valid` is a stall and holds all counters.
- DRAIN:
  - Wait exactly DRAIN cycles with all enables at 0.
  - Then go to STC if st=1, else DONE.
- STC:
  - `c_out_valid`=1 and `en_c`=`c_out_ready`.
  - On the ML-th accepted row, go to DONE.
- DONE:
  - `done`=1 for one cycle, then IDLE. Counters are zeroed on leaving DONE.
- `en_c`, `en_ab`, `c_in_ready`, `ab_ready`, `c_out_valid`, `cmd_ready`, `acc_clr` and `busy` are combinational from the registered state and the inputs named above. `done` is decoded from the DONE state.
- `en_c` and `en_ab` are never high in the same cycle.
- Command inputs are ignored outside IDLE. `c_in_valid`, `ab_valid` and `c_out_ready` are ignored outside their own phases.
- Beat counting wraps at 2^KW. `cmd_k`=2^KW−1 is the largest legal value.

## Timing
- Reset asserted: every output is 0, including `cmd_ready`. This holds for every cycle in which `reset`=1, and reset takes priority in every state.
- Reset in the middle of a command: the next edge forces IDLE and zeroes all counters. The command is dropped and no `done` is issued.
- Latency from accept to `done`, with no stalls: 1 + (ldc?ML:0) + k + DRAIN + (st?ML:0) cycles.
- After `done`, the next `cmd_ready`=1 is in the following cycle. There is no back-to-back overlap.
- Stalls extend the phase one cycle per stall, with no loss or duplication of rows or beats.

## Configuration
- Macro: `MPU_TILE_SEQ_PERF_EN`.
- Defined: `stall_cnt` increments (saturating at 2^32−1) on every cycle in LDC with `c_in_valid`=0, in OPACC with `ab_valid`=0, or in STC with `c_out_ready`=0. It clears on reset only.
- Undefined: no counter logic is built and `stall_cnt` is tied to 0.

## Test plan
- ML=2, DRAIN=3, cmd {k=4, ldc=1, st=1}, all valids/readies held at 1, accepted at cycle 0 -> LDC at cycles 1–2, OPACC at 3–6, DRAIN at 7–9, STC at 10–11, `done` at 12, `cmd_ready`=1 at 13. Required totals: 4 `en_c` pulses, 4 `en_ab` pulses.
- cmd {k=0, ldc=0, st=0} -> `acc_clr`=1 in the accept cycle only; DRAIN at cycles 1–3; `done` at 4; `en_ab` never asserted.
- cmd {k=3, ldc=0, st=1} with `ab_valid` low on the 2nd OPACC cycle -> exactly 3 `en_ab` pulses; `done` one cycle later than the unstalled case. With PERF_EN defined, `stall_cnt`=1.
- STC with `c_out_ready` held low for 5 cycles -> `c_out_valid` stays 1 and `en_c` stays 0 throughout; exactly ML rows are accepted afterwards. With PERF_EN defined, `stall_cnt` increases by 5.
- `reset` pulsed during OPACC beat 2 of k=8 -> all outputs 0 while `reset`=1, then IDLE. A new cmd {k=1} completes normally with exactly one `en_ab`.
- `cmd_valid` held high continuously with 3 queued commands -> each command is accepted only in IDLE. There are 3 `done` pulses, each followed by a `cmd_ready` cycle.
